// File: rtl/q_8_29_pkg.sv
// Shared definitions for the q_8_29 controller and its datapath: state indices,
// the one-hot decode width and the state enum.
package q_8_29_pkg;

  localparam int ONEHOT_W = 8;

  localparam int S0 = 0;
  localparam int S1 = 1;
  localparam int S2 = 2;
  localparam int S3 = 3;
  localparam int S4 = 4;
  localparam int S5 = 5;
  localparam int S6 = 6;
  localparam int S7 = 7;

  typedef enum logic [2:0] {
    ST_S0 = 3'd0,
    ST_S1 = 3'd1,
    ST_S2 = 3'd2,
    ST_S3 = 3'd3,
    ST_S4 = 3'd4,
    ST_S5 = 3'd5,
    ST_S6 = 3'd6,
    ST_S7 = 3'd7
  } state_e;

endpackage

// File: rtl/q_8_29_onehot_chk.sv
// Combinational one-hot checker: valid is high only when exactly one decode bit
// is set; idx is the index of the highest set bit (meaningful only when valid).
module q_8_29_onehot_chk
  import q_8_29_pkg::*;
(
  input  logic [ONEHOT_W-1:0] dec_out,
  output logic                valid,
  output logic [2:0]          idx
);

  logic [3:0] ones;

  always_comb begin
    ones = 4'd0;
    idx  = 3'd0;
    for (int k = 0; k < ONEHOT_W; k++) begin
      if (dec_out[k]) begin
        ones = ones + 4'd1;
        idx  = 3'(k);
      end
    end
    valid = (ones == 4'd1);
  end

endmodule

// File: rtl/q_8_29_datapath.sv
// Datapath stage for the q_8_29 controller: one register transfer per clock on
// accumulator A and a saturating pass counter, selected by the one-hot decode.
// Optional strict one-hot checking with sticky err: Q_8_29_DP_ONEHOT_CHK_EN.
module q_8_29_datapath
  import q_8_29_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [ONEHOT_W-1:0] dec_out,
  output logic [WIDTH-1:0]    a,
  output logic                e,
  output logic                f,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [WIDTH-1:0]    result,
  output logic                done,
  output logic                err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic   op_valid;
  logic [2:0] op_idx;
  state_e op_state;

`ifdef Q_8_29_DP_ONEHOT_CHK_EN
  q_8_29_onehot_chk u_chk (
    .dec_out (dec_out),
    .valid   (op_valid),
    .idx     (op_idx)
  );
`else
  // Priority decode: scanning high to low leaves the lowest set index in op_idx.
  always_comb begin
    op_valid = 1'b0;
    op_idx   = 3'd0;
    for (int k = ONEHOT_W - 1; k >= 0; k--) begin
      if (dec_out[k]) begin
        op_valid = 1'b1;
        op_idx   = 3'(k);
      end
    end
  end

  assign err = 1'b0;
`endif

  assign op_state = state_e'(op_idx);

  // done is the valid strobe for result: high the cycle after each S7 edge.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      a        <= '0;
      pass_cnt <= '0;
      result   <= '0;
      done     <= 1'b0;
`ifdef Q_8_29_DP_ONEHOT_CHK_EN
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef Q_8_29_DP_ONEHOT_CHK_EN
      if (!op_valid) err <= 1'b1;
`endif
      if (op_valid) begin
        case (op_state)
          ST_S0: ;
          ST_S1: begin
            a        <= '0;
            pass_cnt <= '0;
          end
          ST_S2: a <= a + ONE;
          ST_S3: if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
          ST_S4: a <= a + TWO;
          ST_S5: a <= a << 1;
          ST_S6: a <= ~a;
          ST_S7: begin
            result <= a;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign e = a[WIDTH-1];
  assign f = a[0];

endmodule

// File: doc/q_8_29_datapath.md
Name: q_8_29_datapath

Overview:
- Datapath stage directly downstream of the q_8_29 control FSM.
- Consumes the controller's one-hot state decode (dec_out) and performs the register transfers for each state on an accumulator A and a pass counter.
- Produces the status bits E and F, which feed back to the controller's E/F inputs, plus a result/done pair for downstream logic.

Parameters:
- WIDTH, 4, width of accumulator A and result.
- CNT_W, 4, width of pass counter pass_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst_b  in  1  synchronous active-high reset; 1 = reset, sampled on clk rising edge only.
- dec_out  in  8  one-hot state decode from the controller; bit k = state Sk.
- a  out  WIDTH  accumulator register A.
- e  out  1  status to controller; E = a[WIDTH-1], combinational from a.
- f  out  1  status to controller; F = a[0], combinational from a.
- pass_cnt  out  CNT_W  number of S3 visits, saturating.
- result  out  WIDTH  A captured in S7.
- done  out  1  one-cycle pulse after an S7 cycle.
- err  out  1  sticky decode error; tied 0 without the optional feature.

Behaviour:
- Reset: when rst_b=1 at an edge, a=0, pass_cnt=0, result=0, done=0, err=0. Reset overrides every op. A reset in the middle of a sequence discards all state.
- One op per clock, selected by dec_out at the rising edge. The op result is visible the cycle after the edge.
- Because e/f derive from registered a, the controller sees updated E/F in the cycle after the op.
- Op table (arithmetic is modulo 2^WIDTH, wraps silently):
  - S0: hold everything.
  - S1: a<=0, pass_cnt<=0.
  - S2: a<=a+1.
  - S3: pass_cnt<=pass_cnt+1; saturates at 2^CNT_W-1; a holds.
  - S4: a<=a+2.
  - S5: a<=a<<1, LSB filled with 0, MSB discarded.
  - S6: a<=~a.
  - S7: result<=a (pre-edge value); a holds; done<=1 at that edge.
- done: 1 for exactly one cycle after each S7 cycle. Consecutive S7 cycles keep done high and re-capture result each cycle. done<=0 in any non-S7 cycle.
- result holds between S7 visits.
- dec_out==0 with the macro defined: hold all registers, set err.
- dec_out==0 without the macro: hold all registers.
- Multiple bits set: see Optional Feature.

Optional Feature:
- Macro: Q_8_29_DP_ONEHOT_CHK_EN.
- Defined:
  - Any dec_out that is not exactly one-hot (zero or ≥2 bits set) suppresses all register updates that cycle. done still goes to 0.
  - err<=1 and stays 1 until reset.
- Undefined:
  - Priority decode: the lowest set index wins; all-zero means hold.
  - err is constant 0.

Decomposition:
- Shared package q_8_29_pkg: state index constants S0..S7 (0..7), the one-hot width constant 8, and an enum for the state encoding. The controller and this datapath share the package.
- One sub-module is natural: q_8_29_onehot_chk. It is combinational, takes dec_out, and returns valid plus a 3-bit index. It is instantiated only under the macro.

Test Plan (WIDTH=4, CNT_W=4):
- Reset: rst_b=1 for 2 cycles with dec_out=8'h04 → a=0, pass_cnt=0, result=0, done=0, err=0. rst_b=0 then S0 for 3 cycles → all outputs unchanged.
- Counting and status:
  - Sequence S1, S2, S2, S2 → a=3, f=1, e=0.
  - Then S4 → a=5.
  - Then S5 → a=4'hA, e=1, f=0.
  - Then S6 → a=4'h5.
- Wrap:
  - Preload via S1 plus 15×S2, giving a=4'hF, e=1.
  - Then S2 → a=0, e=0.
  - Then S4 from a=4'hF → a=1.
- Saturation: S1 then 20×S3 → pass_cnt=15, held at 15; a unchanged throughout.
- Done/result:
  - With a=5, one S7 then S0 → result=5, done=1 for exactly one cycle.
  - Two consecutive S7 cycles → done high for 2 cycles.
- Bad decode: from a=7, apply dec_out=8'h06.
  - Macro defined: a stays 7, err=1 and stays 1 through subsequent valid ops until rst_b.
  - Macro undefined: S1 wins, so a=0, err=0.
  - dec_out=0 in both builds: a holds.
